uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one TxUnit transmitter among NUM_REQ byte-producing clients.
- Accepts one byte per grant, with that client's parity and baud settings, using round-robin arbitration.
- Drives TxUnit's send, data_in, parity_type and baud_rate, and tracks active_flag and done_flag to report completion per client.
- Sits between the system-side producers and TxUnit in the UART top level.

Parameters:
- NUM_REQ, 4, number of requesting clients (2..8).
- GNT_W, 2, width of grant_id; must be ≥ clog2(NUM_REQ).
- TIMEOUT_CYCLES, 262144, watchdog limit in clock cycles; used only with the optional feature. Covers an 11-bit frame at 2400 baud on 50 MHz.

Ports:
- clock  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  client i requests transmission of one byte
- req_data  in  8*NUM_REQ  byte for client i, in slice [8i+7:8i]
- req_parity  in  2*NUM_REQ  parity_type for client i
- req_baud  in  2*NUM_REQ  baud_rate for client i
- req_ready  out  NUM_REQ  one-cycle pulse: client i's byte accepted
- req_done  out  NUM_REQ  one-cycle pulse: client i's frame completed
- req_err  out  NUM_REQ  one-cycle pulse: client i's frame aborted by timeout (optional feature only; otherwise tied 0)
- tx_send  out  1  to TxUnit send
- tx_data  out  8  to TxUnit data_in
- tx_parity  out  2  to TxUnit parity_type
- tx_baud  out  2  to TxUnit baud_rate
- tx_active  in  1  from TxUnit active_flag
- tx_done  in  1  from TxUnit done_flag
- busy  out  1  high in every state except IDLE
- grant_id  out  GNT_W  index of the client currently owning TxUnit

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr = NUM_REQ-1, so client 0 has first priority.
- Reset mid-frame: asynchronous return to IDLE with tx_send=0. The TxUnit is reset by the same reset_n.
- IDLE: if any req_valid, choose the winner as the first valid index scanning rr_ptr+1, rr_ptr+2, … modulo NUM_REQ. Go to LOAD.
- LOAD (1 cycle):
  - Latch the winner's data, parity and baud into tx_data, tx_parity and tx_baud; set grant_id.
  - Pulse req_ready[winner]. The client may drop or change its inputs afterwards.
  - Go to SEND.
- SEND: tx_send=1; tx_data, tx_parity and tx_baud held stable. When tx_active=1 is sampled, go to WAIT_DONE.
- WAIT_DONE:
  - tx_send=0, which prevents TxUnit starting a second frame.
  - Wait for the rising edge of tx_done, detected as registered previous value 0 and current value 1.
  - A tx_done level already high on entry is ignored.
  - Then go to RELEASE.
- RELEASE (1 cycle): pulse req_done[grant_id]; rr_ptr = grant_id; go to IDLE.
- Latency:
  - req_valid to req_ready is 2 cycles from IDLE.
  - There is a minimum 1-cycle IDLE gap between frames.
- Arbitration is evaluated only in IDLE. Valid inputs that change during a frame are ignored until the next IDLE.
- A client holding req_valid continuously gets at most one frame per round when other clients are waiting.
- Single requester: served back-to-back, one frame per IDLE→RELEASE loop.
- tx_data, tx_parity and tx_baud retain their last values in IDLE; they do not glitch to 0.
- req_ready, req_done and req_err are one-hot or zero, never more than one bit set.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on LOAD and counts during SEND and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES-1: deassert tx_send, pulse req_err[grant_id] instead of req_done, set rr_ptr = grant_id, and return to IDLE via RELEASE.
- Undefined:
  - No counter is built; req_err is tied 0.
  - SEND and WAIT_DONE wait indefinitely.

Decomposition:
- Shared package uart_pkg holds:
  - parity encodings: NONE 2'b00, ODD 2'b01, EVEN 2'b10;
  - baud encodings: 2400 2'b00, 4800 2'b01, 9600 2'b10, 19200 2'b11;
  - the state encoding for IDLE, LOAD, SEND, WAIT_DONE and RELEASE;
  - the TIMEOUT_CYCLES default.
- One sub-module, uart_rr_picker, is combinational: inputs valid vector and rr_ptr; outputs winner index and any-valid.

Test Plan:
- Reset, then req_valid=4'b0001 with data 8'hAA, parity 01, baud 10 → req_ready[0] 2 cycles later; tx_send high until tx_active; req_done[0] about 1.15 ms later; grant_id=0.
- req_valid=4'b1111 held → grant order 0,1,2,3,0; each req_done precedes the next req_ready.
- Client 2 changes req_data after its req_ready → tx_data unchanged for the whole frame.
- Model tx_done high entering WAIT_DONE → ignored; completion only on the next rising edge.
- Assert reset_n=0 mid-WAIT_DONE → all outputs 0 immediately; after release, client 0 has priority.
- With UART_TX_ARB_TIMEOUT_EN and a TxUnit model that never raises tx_active → req_err[grant_id] at TIMEOUT_CYCLES; arbiter serves the next client.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit path: parity/baud codes, arbiter FSM
// states and the default watchdog limit.
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_ODD  = 2'b01;
    localparam logic [1:0] PARITY_EVEN = 2'b10;

    localparam logic [1:0] BAUD_2400  = 2'b00;
    localparam logic [1:0] BAUD_4800  = 2'b01;
    localparam logic [1:0] BAUD_9600  = 2'b10;
    localparam logic [1:0] BAUD_19200 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_DONE,
        ST_RELEASE
    } arb_state_e;

    // One 11-bit frame at 2400 baud from a 50 MHz clock fits comfortably.
    localparam int TIMEOUT_CYCLES_DEFAULT = 262144;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first valid index after rr_ptr_i,
// wrapping modulo NUM_REQ.
module uart_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int GNT_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [GNT_W-1:0]   rr_ptr_i,
    output logic [GNT_W-1:0]   winner_o,
    output logic               any_o
);

    logic [GNT_W:0]   sum;
    logic [GNT_W-1:0] idx;

    // Scan from the farthest offset down so the nearest valid index wins last.
    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            sum = {1'b0, rr_ptr_i} + (GNT_W+1)'(off);
            if (sum >= (GNT_W+1)'(NUM_REQ)) begin
                sum = sum - (GNT_W+1)'(NUM_REQ);
            end
            idx = sum[GNT_W-1:0];
            if (valid_i[idx]) begin
                winner_o = idx;
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one TxUnit among NUM_REQ byte producers.
// Optional watchdog abort enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GNT_W   = 2
`ifdef UART_TX_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
`endif
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [2*NUM_REQ-1:0] req_parity,
    input  logic [2*NUM_REQ-1:0] req_baud,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   req_done,
    output logic [NUM_REQ-1:0]   req_err,
    output logic                 tx_send,
    output logic [7:0]           tx_data,
    output logic [1:0]           tx_parity,
    output logic [1:0]           tx_baud,
    input  logic                 tx_active,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [GNT_W-1:0]     grant_id
);

    arb_state_e         state_q;
    logic [GNT_W-1:0]   rr_ptr_q;
    logic [GNT_W-1:0]   grant_q;
    logic [7:0]         tx_data_q;
    logic [1:0]         tx_parity_q;
    logic [1:0]         tx_baud_q;
    logic               tx_send_q;
    logic               done_prev_q;
    logic [NUM_REQ-1:0] ready_q;
    logic [NUM_REQ-1:0] done_q;
    logic [GNT_W-1:0]   winner;
    logic               anyValid;
    logic               doneRise;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .GNT_W   (GNT_W)
    ) u_picker (
        .valid_i  (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (winner),
        .any_o    (anyValid)
    );

    assign doneRise = tx_done & ~done_prev_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_REQ-1:0] err_q;
    logic               timeoutHit;

    assign timeoutHit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign req_err    = err_q;
`else
    assign req_err = '0;
`endif

    // Single-process FSM; every client-facing pulse is registered on the edge
    // that enters the state it belongs to.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= GNT_W'(NUM_REQ - 1);
            grant_q     <= '0;
            tx_data_q   <= '0;
            tx_parity_q <= '0;
            tx_baud_q   <= '0;
            tx_send_q   <= 1'b0;
            done_prev_q <= 1'b0;
            ready_q     <= '0;
            done_q      <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= '0;
`endif
        end else begin
            ready_q     <= '0;
            done_q      <= '0;
            done_prev_q <= tx_done;
`ifdef UART_TX_ARB_TIMEOUT_EN
            err_q       <= '0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (anyValid) begin
                        grant_q <= winner;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_data_q   <= req_data[{grant_q, 3'b000} +: 8];
                    tx_parity_q <= req_parity[{grant_q, 1'b0} +: 2];
                    tx_baud_q   <= req_baud[{grant_q, 1'b0} +: 2];
                    ready_q     <= NUM_REQ'(1) << grant_q;
                    tx_send_q   <= 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    cnt_q       <= '0;
`endif
                    state_q     <= ST_SEND;
                end
                ST_SEND: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
                    cnt_q <= cnt_q + 1'b1;
                    if (timeoutHit) begin
                        tx_send_q <= 1'b0;
                        err_q     <= NUM_REQ'(1) << grant_q;
                        state_q   <= ST_RELEASE;
                    end else
`endif
                    if (tx_active) begin
                        tx_send_q <= 1'b0;
                        state_q   <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
                    cnt_q <= cnt_q + 1'b1;
                    if (timeoutHit) begin
                        err_q   <= NUM_REQ'(1) << grant_q;
                        state_q <= ST_RELEASE;
                    end else
`endif
                    if (doneRise) begin
                        done_q  <= NUM_REQ'(1) << grant_q;
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    rr_ptr_q <= grant_q;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    tx_send_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign req_done  = done_q;
    assign tx_send   = tx_send_q;
    assign tx_data   = tx_data_q;
    assign tx_parity = tx_parity_q;
    assign tx_baud   = tx_baud_q;
    assign busy      = (state_q != ST_IDLE);
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a small behavioural TxUnit model.
// Define UART_TX_ARB_TIMEOUT_EN to also exercise the watchdog abort path.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N = 4;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TO = 64;
`endif

    logic           clock = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [2*N-1:0] req_parity;
    logic [2*N-1:0] req_baud;
    logic [N-1:0]   req_ready, req_done, req_err;
    logic           tx_send, tx_active, tx_done, busy;
    logic [7:0]     tx_data;
    logic [1:0]     tx_parity, tx_baud, grant_id;

    logic manual, manActive, manDone, modelOn;
    logic mdlActive, mdlDone;
    int   frameLen, mdlCnt;

    int checks = 0;
    int failures = 0;
    int rrModel;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic [1:0] par;
        logic [1:0] baud;
    } exp_t;
    exp_t expQ[$];

    always #10 clock = ~clock;

`ifdef UART_TX_ARB_TIMEOUT_EN
    uart_tx_arbiter #(.NUM_REQ(N), .GNT_W(2), .TIMEOUT_CYCLES(TO)) dut (
`else
    uart_tx_arbiter #(.NUM_REQ(N), .GNT_W(2)) dut (
`endif
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_data(req_data), .req_parity(req_parity), .req_baud(req_baud),
        .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
        .tx_send(tx_send), .tx_data(tx_data), .tx_parity(tx_parity), .tx_baud(tx_baud),
        .tx_active(tx_active), .tx_done(tx_done),
        .busy(busy), .grant_id(grant_id)
    );

    assign tx_active = manual ? manActive : mdlActive;
    assign tx_done   = manual ? manDone   : mdlDone;

    // TxUnit stand-in: picks up send, stays active for frameLen cycles, then
    // raises done until the next frame starts. Shares the arbiter's reset.
    always @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mdlActive <= 1'b0;
            mdlDone   <= 1'b0;
            mdlCnt    <= 0;
        end else if (!mdlActive) begin
            if (tx_send && modelOn) begin
                mdlActive <= 1'b1;
                mdlDone   <= 1'b0;
                mdlCnt    <= frameLen;
            end
        end else if (mdlCnt == 0) begin
            mdlActive <= 1'b0;
            mdlDone   <= 1'b1;
        end else begin
            mdlCnt <= mdlCnt - 1;
        end
    end

    function automatic int pickModel(logic [N-1:0] v, int ptr);
        for (int off = 1; off <= N; off++) begin
            if (v[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    task automatic pushExpected();
        exp_t e;
        e.id   = pickModel(req_valid, rrModel);
        e.data = req_data[e.id*8 +: 8];
        e.par  = req_parity[e.id*2 +: 2];
        e.baud = req_baud[e.id*2 +: 2];
        expQ.push_back(e);
        rrModel = e.id;
    endtask

    task automatic setClient(int i, logic [7:0] d, logic [1:0] p, logic [1:0] b);
        req_data[i*8 +: 8]   = d;
        req_parity[i*2 +: 2] = p;
        req_baud[i*2 +: 2]   = b;
    endtask

    task automatic applyReset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        rrModel = N - 1;
        expQ.delete();
    endtask

    task automatic waitReady(output logic [N-1:0] rdy, output bit ok);
        ok  = 1'b0;
        rdy = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (req_ready != '0) begin
                rdy = req_ready;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitDone(output logic [N-1:0] d, output bit ok, output bit sawReady);
        ok       = 1'b0;
        sawReady = 1'b0;
        d        = '0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (req_ready != '0) sawReady = 1'b1;
            if (req_done != '0) begin
                d  = req_done;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({req_ready, req_done, req_err} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_pulses: got %b want 0", {req_ready, req_done, req_err});
        end
        checks++;
        if ({tx_send, busy, grant_id} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got send=%b busy=%b gnt=%0d want 0", tx_send, busy, grant_id);
        end
        checks++;
        if ({tx_data, tx_parity, tx_baud} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_txregs: got %h want 0", {tx_data, tx_parity, tx_baud});
        end
        reset_n = 1'b1;
        rrModel = N - 1;
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_no_req: busy got %b want 0", busy);
        end
    endtask

    task automatic test_single();
        exp_t e;
        logic [N-1:0] d;
        bit ok, saw, sendDropped;
        setClient(0, 8'hAA, PARITY_ODD, BAUD_9600);
        req_valid = 4'b0001;
        pushExpected();
        @(negedge clock);
        checks++;
        if (req_ready !== '0) begin
            failures++;
            $display("[TB] FAIL single_early_ready: got %b want 0000", req_ready);
        end
        @(negedge clock);
        e = expQ.pop_front();
        checks++;
        if (req_ready !== 4'(1 << e.id) || grant_id !== 2'(e.id)) begin
            failures++;
            $display("[TB] FAIL single_ready: got rdy=%b gnt=%0d want rdy=%b gnt=%0d", req_ready, grant_id, 4'(1 << e.id), e.id);
        end
        checks++;
        if (tx_data !== e.data || tx_parity !== e.par || tx_baud !== e.baud || tx_send !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_load: got %h/%b/%b send=%b want %h/%b/%b send=1", tx_data, tx_parity, tx_baud, tx_send, e.data, e.par, e.baud);
        end
        req_valid   = '0;
        sendDropped = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (tx_active) break;
            if (!tx_send) sendDropped = 1'b1;
        end
        @(negedge clock);
        checks++;
        if (sendDropped || tx_send !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_send: dropped_early=%b send_after_active=%b want 0/0", sendDropped, tx_send);
        end
        waitDone(d, ok, saw);
        checks++;
        if (!ok || d !== 4'(1 << e.id) || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_done: got ok=%b done=%b busy=%b want 1/%b/1", ok, d, busy, 4'(1 << e.id));
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_idle: busy got %b want 0", busy);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        logic [N-1:0] r, d;
        bit ok, saw;
        applyReset();
        for (int i = 0; i < N; i++) setClient(i, 8'h10 + 8'(i), 2'(i % 3), 2'(i));
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) pushExpected();
        for (int k = 0; k < 5; k++) begin
            waitReady(r, ok);
            e = expQ.pop_front();
            checks++;
            if (!ok || r !== 4'(1 << e.id) || tx_data !== e.data) begin
                failures++;
                $display("[TB] FAIL rr_ready_%0d: got ok=%b rdy=%b data=%h want rdy=%b data=%h", k, ok, r, tx_data, 4'(1 << e.id), e.data);
            end
            waitDone(d, ok, saw);
            if (k == 4) req_valid = '0;
            checks++;
            if (!ok || saw || d !== 4'(1 << e.id)) begin
                failures++;
                $display("[TB] FAIL rr_done_%0d: got ok=%b extra_ready=%b done=%b want done=%b", k, ok, saw, d, 4'(1 << e.id));
            end
        end
    endtask

    task automatic test_data_hold();
        exp_t e;
        logic [N-1:0] r, d;
        bit ok;
        int holdErr;
        setClient(2, 8'h5C, PARITY_EVEN, BAUD_19200);
        req_valid = 4'b0100;
        pushExpected();
        waitReady(r, ok);
        e = expQ.pop_front();
        checks++;
        if (!ok || r !== 4'(1 << e.id)) begin
            failures++;
            $display("[TB] FAIL hold_ready: got ok=%b rdy=%b want %b", ok, r, 4'(1 << e.id));
        end
        setClient(2, 8'hFF, PARITY_NONE, BAUD_2400);
        req_valid = '0;
        holdErr   = 0;
        ok        = 1'b0;
        d         = '0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (tx_data !== e.data || tx_parity !== e.par || tx_baud !== e.baud) holdErr++;
            if (req_done != '0) begin
                d  = req_done;
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (holdErr != 0 || !ok || d !== 4'(1 << e.id)) begin
            failures++;
            $display("[TB] FAIL hold_frame: got changes=%0d ok=%b done=%b want 0/1/%b", holdErr, ok, d, 4'(1 << e.id));
        end
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || tx_data !== e.data || tx_parity !== e.par || tx_baud !== e.baud) begin
            failures++;
            $display("[TB] FAIL hold_idle: got busy=%b %h/%b/%b want 0 %h/%b/%b", busy, tx_data, tx_parity, tx_baud, e.data, e.par, e.baud);
        end
    endtask

    task automatic test_done_high();
        exp_t e;
        logic [N-1:0] r, d;
        bit ok, saw, early;
        manual    = 1'b1;
        manActive = 1'b0;
        manDone   = 1'b1;
        setClient(1, 8'h96, PARITY_ODD, BAUD_4800);
        req_valid = 4'b0010;
        pushExpected();
        waitReady(r, ok);
        e = expQ.pop_front();
        req_valid = '0;
        checks++;
        if (!ok || r !== 4'(1 << e.id)) begin
            failures++;
            $display("[TB] FAIL dh_ready: got ok=%b rdy=%b want %b", ok, r, 4'(1 << e.id));
        end
        manActive = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (req_done != '0 || !busy) early = 1'b1;
        end
        checks++;
        if (early) begin
            failures++;
            $display("[TB] FAIL dh_level_ignored: got early completion=1 want 0");
        end
        manActive = 1'b0;
        manDone   = 1'b0;
        @(negedge clock);
        manDone = 1'b1;
        waitDone(d, ok, saw);
        checks++;
        if (!ok || d !== 4'(1 << e.id)) begin
            failures++;
            $display("[TB] FAIL dh_edge_done: got ok=%b done=%b want %b", ok, d, 4'(1 << e.id));
        end
        @(negedge clock);
        manual  = 1'b0;
        manDone = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [N-1:0] r, d;
        bit ok, saw;
        frameLen = 200;
        setClient(3, 8'h77, PARITY_EVEN, BAUD_2400);
        req_valid = 4'b1000;
        pushExpected();
        waitReady(r, ok);
        e = expQ.pop_front();
        req_valid = '0;
        checks++;
        if (!ok || r !== 4'(1 << e.id)) begin
            failures++;
            $display("[TB] FAIL rm_ready: got ok=%b rdy=%b want %b", ok, r, 4'(1 << e.id));
        end
        for (int i = 0; i < 50 && !tx_active; i++) @(negedge clock);
        repeat (5) @(negedge clock);
        checks++;
        if (busy !== 1'b1 || tx_send !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rm_in_wait: got busy=%b send=%b want 1/0", busy, tx_send);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, req_done, req_err, tx_send, busy, grant_id, tx_data, tx_parity, tx_baud} !== '0) begin
            failures++;
            $display("[TB] FAIL rm_async_clear: got %h want 0", {req_ready, req_done, req_err, tx_send, busy, grant_id, tx_data, tx_parity, tx_baud});
        end
        @(negedge clock);
        reset_n  = 1'b1;
        rrModel  = N - 1;
        frameLen = 20;
        expQ.delete();
        setClient(0, 8'h3C, PARITY_NONE, BAUD_9600);
        req_valid = 4'b1001;
        pushExpected();
        waitReady(r, ok);
        e = expQ.pop_front();
        req_valid = '0;
        checks++;
        if (!ok || r !== 4'(1 << e.id) || tx_data !== e.data) begin
            failures++;
            $display("[TB] FAIL rm_priority: got ok=%b rdy=%b data=%h want rdy=%b data=%h", ok, r, tx_data, 4'(1 << e.id), e.data);
        end
        waitDone(d, ok, saw);
        checks++;
        if (!ok || d !== 4'(1 << e.id)) begin
            failures++;
            $display("[TB] FAIL rm_done: got ok=%b done=%b want %b", ok, d, 4'(1 << e.id));
        end
        @(negedge clock);
    endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        logic [N-1:0] r, d, errSeen;
        bit ok, saw, doneSeen;
        int cycles;
        modelOn = 1'b0;
        setClient(1, 8'hE1, PARITY_ODD, BAUD_19200);
        setClient(2, 8'hE2, PARITY_EVEN, BAUD_4800);
        req_valid = 4'b0110;
        pushExpected();
        waitReady(r, ok);
        e = expQ.pop_front();
        checks++;
        if (!ok || r !== 4'(1 << e.id)) begin
            failures++;
            $display("[TB] FAIL to_ready: got ok=%b rdy=%b want %b", ok, r, 4'(1 << e.id));
        end
        cycles   = 0;
        errSeen  = '0;
        doneSeen = 1'b0;
        for (int i = 0; i < TO + 50; i++) begin
            @(negedge clock);
            cycles++;
            if (req_done != '0) doneSeen = 1'b1;
            if (req_err != '0) begin
                errSeen = req_err;
                break;
            end
        end
        checks++;
        if (errSeen !== 4'(1 << e.id) || cycles != TO || doneSeen || tx_send !== 1'b0) begin
            failures++;
            $display("[TB] FAIL to_err: got err=%b after %0d done=%b send=%b want err=%b after %0d", errSeen, cycles, doneSeen, tx_send, 4'(1 << e.id), TO);
        end
        modelOn   = 1'b1;
        req_valid = 4'b0100;
        pushExpected();
        waitReady(r, ok);
        e = expQ.pop_front();
        req_valid = '0;
        checks++;
        if (!ok || r !== 4'(1 << e.id) || tx_data !== e.data) begin
            failures++;
            $display("[TB] FAIL to_next: got ok=%b rdy=%b data=%h want rdy=%b data=%h", ok, r, tx_data, 4'(1 << e.id), e.data);
        end
        waitDone(d, ok, saw);
        checks++;
        if (!ok || d !== 4'(1 << e.id)) begin
            failures++;
            $display("[TB] FAIL to_next_done: got ok=%b done=%b want %b", ok, d, 4'(1 << e.id));
        end
    endtask
`endif

    initial begin
        #2_000_000;
        failures++;
        $display("[TB] FAIL watchdog: got simulation still running want finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_parity = '0;
        req_baud   = '0;
        manual     = 1'b0;
        manActive  = 1'b0;
        manDone    = 1'b0;
        modelOn    = 1'b1;
        frameLen   = 20;
        rrModel    = N - 1;
        test_reset();
        test_single();
        test_round_robin();
        test_data_hold();
        test_done_high();
        test_reset_mid();
`ifdef UART_TX_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
